// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped, 4-word-block cache and its backing memory.
// Accepts one read request at a time, looks up the tag, runs a block read and a
// fill on a miss, then returns a one-cycle response.
// It also keeps saturating access and hit counters.
module cache_controller #(
    parameter int ADDR_W  = 15,
    parameter int TAG_W   = 3,
    parameter int INDEX_W = 10,
    parameter int COUNT_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_adr,
    output logic               req_ready,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [INDEX_W-1:0] cache_indx,
    output logic [TAG_W-1:0]   cache_tag_in,
    input  logic               cache_valid,
    input  logic [TAG_W-1:0]   cache_tag,
    output logic               cache_write,
    output logic [ADDR_W-1:0]  mem_adr,
    output logic               mem_read,
    input  logic               mem_ready,
    output logic [COUNT_W-1:0] access_count,
    output logic [COUNT_W-1:0] hit_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        FILL,
        RESP
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                resp_hit_q, resp_hit_d;
    logic [COUNT_W-1:0]  access_count_q, access_count_d;
    logic [COUNT_W-1:0]  hit_count_q, hit_count_d;
    logic                lookup_hit;

    // The cache answers combinationally for the index and tag of the captured address.
    assign lookup_hit = cache_valid && (cache_tag == addr_q[ADDR_W-1 -: TAG_W]);

    // Next-state, address capture, hit latch and saturating statistics.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        resp_hit_d     = resp_hit_q;
        access_count_d = access_count_q;
        hit_count_d    = hit_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_adr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_hit_d = lookup_hit;
                if (access_count_q != COUNT_MAX) begin
                    access_count_d = access_count_q + COUNT_W'(1);
                end
                if (lookup_hit && (hit_count_q != COUNT_MAX)) begin
                    hit_count_d = hit_count_q + COUNT_W'(1);
                end
                state_d = lookup_hit ? RESP : MISS;
            end
            MISS: begin
                if (mem_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight request at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            resp_hit_q     <= 1'b0;
            access_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            resp_hit_q     <= resp_hit_d;
            access_count_q <= access_count_d;
            hit_count_q    <= hit_count_d;
        end
    end

    // All outputs come from the state and registers only.
    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_hit     = (state_q == RESP) && resp_hit_q;
    assign cache_write  = (state_q == FILL);
    assign mem_read     = (state_q == MISS);
    assign mem_adr      = addr_q;
    assign cache_indx   = addr_q[INDEX_W+1:2];
    assign cache_tag_in = addr_q[ADDR_W-1 -: TAG_W];
    assign access_count = access_count_q;
    assign hit_count    = hit_count_q;

endmodule
